// File: rtl/instruction_queue.sv
// Fetch-to-decode instruction FIFO holding {pc, pc_next, inst} entries.
// First-word-fall-through head with valid/ready dequeue; flush discards everything.
module instruction_queue #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq_valid,
    input  logic [31:0]   enq_pc,
    input  logic [31:0]   enq_pc_next,
    input  logic [31:0]   enq_inst,
    output logic          full,
    output logic          deq_valid,
    input  logic          deq_ready,
    output logic [31:0]   deq_pc,
    output logic [31:0]   deq_pc_next,
    output logic [31:0]   deq_inst,
    input  logic          flush,
    output logic [CW-1:0] count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [95:0]   r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_enq_fire;
    logic          w_deq_fire;
    logic [95:0]   w_head_entry;

    // full comes only from the registered count, so a same-cycle deq never frees a slot for enq
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_enq_fire = enq_valid & ~w_full & ~flush;
    assign w_deq_fire = ~w_empty & deq_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq_fire) r_tail <= r_tail + AW'(1);
            if (w_deq_fire) r_head <= r_head + AW'(1);
            r_count <= r_count + CW'(w_enq_fire) - CW'(w_deq_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq_fire) r_mem[r_tail] <= {enq_pc, enq_pc_next, enq_inst};
    end

    always_comb begin
        w_head_entry = r_mem[r_head];
        deq_pc       = '0;
        deq_pc_next  = '0;
        deq_inst     = '0;
        if (!w_empty) begin
            deq_pc      = w_head_entry[95:64];
            deq_pc_next = w_head_entry[63:32];
            deq_inst    = w_head_entry[31:0];
        end
    end

    assign full      = w_full;
    assign deq_valid = ~w_empty;
    assign count     = r_count;

endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: a queue-based reference model acts as scoreboard,
// a vector table covers basic handshakes, hand-written sequences cover fill/wrap/flush/reset.
module tb_instruction_queue;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enq_valid;
    logic [31:0]   enq_pc;
    logic [31:0]   enq_pc_next;
    logic [31:0]   enq_inst;
    logic          full;
    logic          deq_valid;
    logic          deq_ready;
    logic [31:0]   deq_pc;
    logic [31:0]   deq_pc_next;
    logic [31:0]   deq_inst;
    logic          flush;
    logic [CW-1:0] count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [95:0] mq[$];

    typedef struct {
        logic        ev;
        logic        dr;
        logic        fl;
        logic [31:0] pc;
        int unsigned exp_count;
        logic        exp_full;
        logic        exp_dvalid;
    } vec_t;

    vec_t vecs[12];

    instruction_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .enq_valid   (enq_valid),
        .enq_pc      (enq_pc),
        .enq_pc_next (enq_pc_next),
        .enq_inst    (enq_inst),
        .full        (full),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_pc      (deq_pc),
        .deq_pc_next (deq_pc_next),
        .deq_inst    (deq_inst),
        .flush       (flush),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc << 4) | 32'h13;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, score any dequeue, advance the model, then check visible state.
    task automatic cyc(input logic ev, input logic dr, input logic fl, input logic rs,
                       input logic [31:0] pc);
        logic        m_full;
        logic [95:0] e;
        m_full      = (mq.size() == DEPTH);
        enq_valid   = ev;
        deq_ready   = dr;
        flush       = fl;
        rst         = rs;
        enq_pc      = pc;
        enq_pc_next = pc + 32'd4;
        enq_inst    = inst_of(pc);
        @(negedge clk);
        if (dr && !fl && !rs && mq.size() != 0) begin
            e = mq.pop_front();
            chk("deq_data", {deq_pc, deq_pc_next, deq_inst}, e);
        end
        if (rs || fl) mq.delete();
        else if (ev && !m_full) mq.push_back({pc, pc + 32'd4, inst_of(pc)});
        @(posedge clk);
        #1;
        chk("count", 96'(count), 96'(mq.size()));
        chk("full", 96'(full), 96'(mq.size() == DEPTH));
        chk("deq_valid", 96'(deq_valid), 96'(mq.size() != 0));
        chk("head", {deq_pc, deq_pc_next, deq_inst}, (mq.size() != 0) ? mq[0] : 96'h0);
    endtask

    initial begin
        logic [31:0] base;
        rst = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
        enq_pc = '0; enq_pc_next = '0; enq_inst = '0;

        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("reset_count", 96'(count), 96'h0);
        chk("reset_deq_pc", 96'(deq_pc), 96'h0);

        // basic handshakes, empty-side underflow, flush with enq+deq
        vecs[0]  = '{1, 0, 0, 32'h6000_0000, 1, 0, 1};
        vecs[1]  = '{0, 0, 0, 32'h0,         1, 0, 1};
        vecs[2]  = '{0, 1, 0, 32'h0,         0, 0, 0};
        vecs[3]  = '{0, 1, 0, 32'h0,         0, 0, 0};
        vecs[4]  = '{0, 1, 0, 32'h0,         0, 0, 0};
        vecs[5]  = '{0, 1, 0, 32'h0,         0, 0, 0};
        vecs[6]  = '{1, 0, 0, 32'h6000_0100, 1, 0, 1};
        vecs[7]  = '{1, 1, 0, 32'h6000_0104, 1, 0, 1};
        vecs[8]  = '{1, 0, 0, 32'h6000_0108, 2, 0, 1};
        vecs[9]  = '{1, 1, 1, 32'h6000_010c, 0, 0, 0};
        vecs[10] = '{1, 1, 0, 32'h6000_0110, 1, 0, 1};
        vecs[11] = '{0, 1, 0, 32'h0,         0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].ev, vecs[i].dr, vecs[i].fl, 0, vecs[i].pc);
            chk("vec_count", 96'(count), 96'(vecs[i].exp_count));
            chk("vec_full", 96'(full), 96'(vecs[i].exp_full));
            chk("vec_dvalid", 96'(deq_valid), 96'(vecs[i].exp_dvalid));
        end
        chk("first_entry_inst", 96'(inst_of(32'h6000_0000)), 96'h13);

        // fill to full, drop a 17th, then drain in order
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 32'h6000_0000 + 32'(4 * i));
        chk("fill_full", 96'(full), 96'h1);
        chk("fill_count", 96'(count), 96'd16);
        cyc(1, 0, 0, 0, 32'h6000_0040);
        chk("drop_count", 96'(count), 96'd16);
        cyc(1, 1, 0, 0, 32'h6000_0044);
        chk("full_after_deq", 96'(full), 96'h0);
        chk("count_after_deq", 96'(count), 96'd15);
        chk("head_after_deq", 96'(deq_pc), 96'h6000_0004);
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0, 0);
        chk("drained", 96'(count), 96'h0);

        // steady occupancy 8 with simultaneous enq/deq, wrapping both pointers
        base = 32'h6000_1000;
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, base + 32'(4 * i));
        for (int k = 0; k < 40; k++) begin
            chk("wrap_seq", 96'(deq_pc), 96'(base + 32'(4 * k)));
            cyc(1, 1, 0, 0, base + 32'(4 * (8 + k)));
        end
        chk("wrap_count", 96'(count), 96'd8);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0);

        // flush with count=5 overrides enq and deq
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 32'h6000_2000 + 32'(4 * i));
        cyc(1, 1, 1, 0, 32'h6000_2100);
        chk("flush_count", 96'(count), 96'h0);
        chk("flush_dvalid", 96'(deq_valid), 96'h0);
        chk("flush_deq_pc", 96'(deq_pc), 96'h0);
        cyc(0, 0, 0, 0, 0);
        chk("flush_no_store", 96'(count), 96'h0);

        // reset mid-operation with enq pending, then a fresh enqueue
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 32'h6000_3000 + 32'(4 * i));
        cyc(1, 1, 0, 1, 32'h6000_3100);
        chk("rst_count", 96'(count), 96'h0);
        chk("rst_full", 96'(full), 96'h0);
        chk("rst_deq", {deq_pc, deq_pc_next, deq_inst}, 96'h0);
        cyc(1, 0, 0, 0, 32'h6000_0000);
        chk("post_rst_pc", 96'(deq_pc), 96'h6000_0000);
        chk("post_rst_count", 96'(count), 96'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 required");
        $fatal(1);
    end

endmodule
